// File: rtl/fe_pkg.sv
// Shared types and helpers for the fetch controller and its fetch queue.
package fe_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, NUKE_WAIT} t_fe_fsm;

    typedef enum logic [1:0] {FREE, PEND, FULL, ZOMBIE} t_fq_st;

    // Wrap-aware age compare: a is older than b when its distance from the
    // ROB head (mod 2^w) is smaller.
    function automatic logic f_robid_a_older_b(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic [31:0] oldest,
                                               input int          w);
        logic [31:0] mask;
        logic [31:0] dist_a;
        logic [31:0] dist_b;
        mask   = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        dist_a = (a - oldest) & mask;
        dist_b = (b - oldest) & mask;
        return dist_a < dist_b;
    endfunction

endpackage

// File: rtl/fe_fetch_queue.sv
// Fetch queue: slot allocation for fill-buffer requests, out-of-order fill,
// in-order drain to decode, and flush handling with zombie tracking.
module fe_fetch_queue
    import fe_pkg::*;
#(
    parameter int PADDR_W  = 32,
    parameter int FQ_DEPTH = 4,
    localparam int ID_W    = $clog2(FQ_DEPTH),
    localparam int OCC_W   = $clog2(FQ_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    input  logic               flush,
    input  logic [PADDR_W-1:0] req_pc,
    output logic               req_valid,
    output logic [ID_W-1:0]    req_id,
    input  logic               req_ready,
    output logic               req_accept,
    input  logic               rsp_valid,
    input  logic [ID_W-1:0]    rsp_id,
    input  logic [31:0]        rsp_instr,
    output logic               deq_valid,
    output logic [31:0]        deq_instr,
    output logic [PADDR_W-1:0] deq_pc,
    input  logic               deq_ready,
    output logic [OCC_W-1:0]   occupancy
);

    t_fq_st             st_vec    [FQ_DEPTH];
    logic [PADDR_W-1:0] pc_vec    [FQ_DEPTH];
    logic [31:0]        instr_vec [FQ_DEPTH];

    logic [ID_W-1:0]  head_reg;
    logic [ID_W-1:0]  tail_reg;
    logic [OCC_W-1:0] occ_reg;
    logic             deq_fire;

    // Requests are withdrawn in a flush cycle, so acceptance never races a flush.
    assign req_valid  = fetch_en & ~flush & (st_vec[tail_reg] == FREE)
                      & (occ_reg < OCC_W'(FQ_DEPTH));
    assign req_id     = tail_reg;
    assign req_accept = req_valid & req_ready;

    // Decode only ever sees the head slot; no same-cycle bypass from the response.
    assign deq_valid  = fetch_en & ~flush & (st_vec[head_reg] == FULL);
    assign deq_fire   = deq_valid & deq_ready;
    assign deq_instr  = instr_vec[head_reg];
    assign deq_pc     = pc_vec[head_reg];
    assign occupancy  = occ_reg;

    for (genvar gi = 0; gi < FQ_DEPTH; gi++) begin : g_entry
        t_fq_st             st_reg;
        t_fq_st             st_next;
        logic [PADDR_W-1:0] pc_reg;
        logic [31:0]        instr_reg;
        logic               rsp_hit;
        logic               alloc_hit;
        logic               deq_hit;

        assign rsp_hit   = rsp_valid  & (rsp_id   == ID_W'(gi));
        assign alloc_hit = req_accept & (tail_reg == ID_W'(gi));
        assign deq_hit   = deq_fire   & (head_reg == ID_W'(gi));

        // Slot lifecycle; a flush turns outstanding fills into zombies unless
        // their response lands in the same cycle.
        always_comb begin
            st_next = st_reg;
            if (flush) begin
                case (st_reg)
                    PEND:    st_next = rsp_hit ? FREE : ZOMBIE;
                    FULL:    st_next = FREE;
                    ZOMBIE:  if (rsp_hit) st_next = FREE;
                    default: st_next = st_reg;
                endcase
            end else begin
                case (st_reg)
                    FREE:    if (alloc_hit) st_next = PEND;
                    PEND:    if (rsp_hit)   st_next = FULL;
                    FULL:    if (deq_hit)   st_next = FREE;
                    ZOMBIE:  if (rsp_hit)   st_next = FREE;
                    default: st_next = st_reg;
                endcase
            end
        end

        // Slot state register.
        always_ff @(posedge clk) begin
            if (reset) st_reg <= FREE;
            else       st_reg <= st_next;
        end

        // Slot payload: PC at allocation, instruction when a live fill returns.
        always_ff @(posedge clk) begin
            if (alloc_hit) pc_reg <= req_pc;
            if (rsp_hit && !flush && st_reg == PEND) instr_reg <= rsp_instr;
        end

        assign st_vec[gi]    = st_reg;
        assign pc_vec[gi]    = pc_reg;
        assign instr_vec[gi] = instr_reg;
    end

    // Pointers and live-entry count; a flush empties the live window at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg <= '0;
            tail_reg <= '0;
            occ_reg  <= '0;
        end else if (flush) begin
            head_reg <= tail_reg;
            occ_reg  <= '0;
        end else begin
            if (req_accept) tail_reg <= tail_reg + ID_W'(1);
            if (deq_fire)   head_reg <= head_reg + ID_W'(1);
            occ_reg <= occ_reg + OCC_W'(req_accept) - OCC_W'(deq_fire);
        end
    end

    // A response must target a slot that is waiting for one.
    always_ff @(posedge clk) begin
        if (!reset && rsp_valid)
            assert (st_vec[rsp_id] == PEND || st_vec[rsp_id] == ZOMBIE);
    end

endmodule

// File: rtl/fe_ctl_fq.sv
// Fetch controller top: fetch FSM, fetch PC, mispredict arbitration, and the
// fetch queue that reorders fill-buffer responses for decode.
module fe_ctl_fq
    import fe_pkg::*;
#(
    parameter int PADDR_W  = 32,
    parameter int FQ_DEPTH = 4,
    parameter int ROBID_W  = 6,
    localparam int ID_W    = $clog2(FQ_DEPTH),
    localparam int OCC_W   = $clog2(FQ_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PADDR_W-1:0] boot_pc,
    input  logic               nuke_valid,
    input  logic [PADDR_W-1:0] nuke_pc,
    input  logic               resume_fetch,
    input  logic               br_mispred_valid,
    input  logic [ROBID_W-1:0] br_mispred_robid,
    input  logic [PADDR_W-1:0] br_mispred_target,
    input  logic [ROBID_W-1:0] oldest_robid,
    output logic               fb_req_valid,
    output logic [PADDR_W-1:0] fb_req_addr,
    output logic [ID_W-1:0]    fb_req_id,
    input  logic               fb_req_ready,
    input  logic               fb_rsp_valid,
    input  logic [ID_W-1:0]    fb_rsp_id,
    input  logic [31:0]        fb_rsp_instr,
    output logic               valid_fe1,
    output logic [31:0]        instr_fe1,
    output logic [PADDR_W-1:0] pc_fe1,
    input  logic               decode_ready_de0,
    output logic [OCC_W-1:0]   fq_occupancy
);

    t_fe_fsm            state_reg;
    t_fe_fsm            state_next;
    logic [PADDR_W-1:0] pc_reg;
    logic               mp_pdg_reg;
    logic [ROBID_W-1:0] mp_robid_reg;
    logic               br_is_older;
    logic               mp_ql;
    logic               flush_now;
    logic               req_accept;

    // Once a mispredict is pending, only an older branch may redirect again.
    assign br_is_older = f_robid_a_older_b(32'(br_mispred_robid), 32'(mp_robid_reg),
                                           32'(oldest_robid), ROBID_W);
    assign mp_ql       = br_mispred_valid & ~nuke_valid & (~mp_pdg_reg | br_is_older);
    assign flush_now   = mp_ql | nuke_valid;
    assign fb_req_addr = pc_reg;

    // Next-state logic: one idle cycle out of reset, then fetch until a nuke.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      state_next = FETCH;
            FETCH:     if (nuke_valid) state_next = NUKE_WAIT;
            NUKE_WAIT: if (resume_fetch && !nuke_valid) state_next = FETCH;
            default:   state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Fetch PC: redirect on flush (nuke wins), otherwise advance per accepted request.
    always_ff @(posedge clk) begin
        if (reset)             pc_reg <= boot_pc;
        else if (nuke_valid)   pc_reg <= nuke_pc;
        else if (mp_ql)        pc_reg <= br_mispred_target;
        else if (req_accept)   pc_reg <= pc_reg + PADDR_W'(4);
    end

    // Pending-mispredict tracking; a nuke supersedes any outstanding redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            mp_pdg_reg   <= 1'b0;
            mp_robid_reg <= '0;
        end else begin
            if (nuke_valid)            mp_pdg_reg <= 1'b0;
            else if (br_mispred_valid) mp_pdg_reg <= 1'b1;
            if (mp_ql) mp_robid_reg <= br_mispred_robid;
        end
    end

    fe_fetch_queue #(
        .PADDR_W  (PADDR_W),
        .FQ_DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk        (clk),
        .reset      (reset),
        .fetch_en   (state_reg == FETCH),
        .flush      (flush_now),
        .req_pc     (pc_reg),
        .req_valid  (fb_req_valid),
        .req_id     (fb_req_id),
        .req_ready  (fb_req_ready),
        .req_accept (req_accept),
        .rsp_valid  (fb_rsp_valid),
        .rsp_id     (fb_rsp_id),
        .rsp_instr  (fb_rsp_instr),
        .deq_valid  (valid_fe1),
        .deq_instr  (instr_fe1),
        .deq_pc     (pc_fe1),
        .deq_ready  (decode_ready_de0),
        .occupancy  (fq_occupancy)
    );

endmodule

// File: tb/tb_fe_ctl_fq.sv
// Bench for fe_ctl_fq: a fill-buffer environment plus a reference model of the
// program-order instruction stream, checked every cycle.
module tb_fe_ctl_fq;

    localparam int PADDR_W  = 32;
    localparam int FQ_DEPTH = 4;
    localparam int ROBID_W  = 6;
    localparam int ID_W     = 2;
    localparam int OCC_W    = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic [PADDR_W-1:0] boot_pc;
    logic               nuke_valid;
    logic [PADDR_W-1:0] nuke_pc;
    logic               resume_fetch;
    logic               br_mispred_valid;
    logic [ROBID_W-1:0] br_mispred_robid;
    logic [PADDR_W-1:0] br_mispred_target;
    logic [ROBID_W-1:0] oldest_robid;
    logic               fb_req_valid;
    logic [PADDR_W-1:0] fb_req_addr;
    logic [ID_W-1:0]    fb_req_id;
    logic               fb_req_ready;
    logic               fb_rsp_valid;
    logic [ID_W-1:0]    fb_rsp_id;
    logic [31:0]        fb_rsp_instr;
    logic               valid_fe1;
    logic [31:0]        instr_fe1;
    logic [PADDR_W-1:0] pc_fe1;
    logic               decode_ready_de0;
    logic [OCC_W-1:0]   fq_occupancy;

    always #5 clk = ~clk;

    fe_ctl_fq #(.PADDR_W(PADDR_W), .FQ_DEPTH(FQ_DEPTH), .ROBID_W(ROBID_W)) dut (
        .clk(clk), .reset(reset), .boot_pc(boot_pc),
        .nuke_valid(nuke_valid), .nuke_pc(nuke_pc), .resume_fetch(resume_fetch),
        .br_mispred_valid(br_mispred_valid), .br_mispred_robid(br_mispred_robid),
        .br_mispred_target(br_mispred_target), .oldest_robid(oldest_robid),
        .fb_req_valid(fb_req_valid), .fb_req_addr(fb_req_addr), .fb_req_id(fb_req_id),
        .fb_req_ready(fb_req_ready), .fb_rsp_valid(fb_rsp_valid), .fb_rsp_id(fb_rsp_id),
        .fb_rsp_instr(fb_rsp_instr), .valid_fe1(valid_fe1), .instr_fe1(instr_fe1),
        .pc_fe1(pc_fe1), .decode_ready_de0(decode_ready_de0), .fq_occupancy(fq_occupancy)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Outstanding fill-buffer requests; 'cur' is cleared when a flush orphans them.
    typedef struct { int id; logic [31:0] addr; int due; bit cur; } fb_item_t;
    // Accepted, not yet delivered, not flushed requests in program order.
    typedef struct { int id; logic [31:0] addr; bit arrived; } live_t;
    fb_item_t fb_q[$];
    live_t    live_q[$];

    // Environment knobs.
    int cyc       = 0;
    int fb_lat    = 2;
    int fb_jitter = 0;
    bit fb_manual = 0;
    int manual_id = -1;
    int fb_budget = -1;
    int rdy_pct   = 100;
    int dec_pct   = 100;

    // Reference model state.
    int          m_st = 0;   // 0 idle, 1 fetching, 2 waiting for resume
    logic [31:0] m_pc;
    bit          m_pdg;
    int          m_mp_robid;
    int          m_accepts;
    bit          m_ok = 0;
    int          delivered = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic bit older(input int a, input int b, input int o);
        int mask;
        mask = (1 << ROBID_W) - 1;
        return ((a - o) & mask) < ((b - o) & mask);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive environment, check outputs against the model, advance both.
    task automatic cycle();
        int       pick;
        int       nid;
        bit       ql;
        bit       flush;
        bit       exp_req;
        bit       exp_vld;
        bit       busy;
        fb_item_t it;
        live_t    lv;

        pick = -1;
        if (reset) begin
            fb_req_ready     = 1'b0;
            decode_ready_de0 = 1'b0;
        end else begin
            fb_req_ready     = (fb_budget != 0) && (int'($urandom_range(99)) < rdy_pct);
            decode_ready_de0 = int'($urandom_range(99)) < dec_pct;
            if (fb_manual) begin
                for (int i = 0; i < fb_q.size(); i++)
                    if (fb_q[i].id == manual_id) pick = i;
                manual_id = -1;
            end else begin
                for (int i = 0; i < fb_q.size(); i++)
                    if (fb_q[i].due <= cyc) begin
                        if (pick < 0) pick = i;
                        else if (fb_jitter > 0 && $urandom_range(1) == 1) pick = i;
                    end
            end
        end
        fb_rsp_valid = (pick >= 0);
        fb_rsp_id    = (pick >= 0) ? ID_W'(fb_q[pick].id) : ID_W'($urandom);
        fb_rsp_instr = (pick >= 0) ? instr_of(fb_q[pick].addr) : $urandom;
        #1;

        ql    = br_mispred_valid && !nuke_valid &&
                (!m_pdg || older(int'(br_mispred_robid), m_mp_robid, int'(oldest_robid)));
        flush = nuke_valid || ql;
        nid   = m_accepts % FQ_DEPTH;
        busy  = live_q.size() >= FQ_DEPTH;
        foreach (fb_q[i]) if (!fb_q[i].cur && fb_q[i].id == nid) busy = 1;
        exp_req = (m_st == 1) && !flush && !busy;
        exp_vld = (m_st == 1) && !flush && live_q.size() > 0 && live_q[0].arrived;

        if (m_ok) begin
            chk("req_valid", 32'(fb_req_valid), 32'(exp_req));
            chk("valid_fe1", 32'(valid_fe1), 32'(exp_vld));
            chk("occupancy", 32'(fq_occupancy), 32'(live_q.size()));
            if (exp_req && fb_req_valid) begin
                chk("req_addr", fb_req_addr, m_pc);
                chk("req_id", 32'(fb_req_id), 32'(nid));
            end
            if (exp_vld && valid_fe1) begin
                chk("pc_fe1", pc_fe1, live_q[0].addr);
                chk("instr_fe1", instr_fe1, instr_of(live_q[0].addr));
            end
        end

        if (reset) begin
            fb_q.delete();
            live_q.delete();
            m_st = 0; m_pc = boot_pc; m_pdg = 0; m_mp_robid = 0; m_accepts = 0;
            m_ok = 1;
        end else begin
            if (pick >= 0) begin
                if (fb_q[pick].cur && !flush)
                    for (int i = 0; i < live_q.size(); i++)
                        if (live_q[i].id == fb_q[pick].id) begin
                            lv = live_q[i]; lv.arrived = 1; live_q[i] = lv;
                        end
                fb_q.delete(pick);
            end
            if (flush) begin
                for (int i = 0; i < fb_q.size(); i++) begin
                    it = fb_q[i]; it.cur = 0; fb_q[i] = it;
                end
                live_q.delete();
                m_pc = nuke_valid ? nuke_pc : br_mispred_target;
            end else begin
                if (exp_req && fb_req_ready) begin
                    it.id = nid; it.addr = m_pc; it.cur = 1;
                    it.due = cyc + fb_lat + ((fb_jitter > 0) ? int'($urandom_range(fb_jitter)) : 0);
                    fb_q.push_back(it);
                    lv.id = nid; lv.addr = m_pc; lv.arrived = 0;
                    live_q.push_back(lv);
                    m_pc = m_pc + 32'd4;
                    m_accepts++;
                    if (fb_budget > 0) fb_budget--;
                end
                if (exp_vld && decode_ready_de0) begin
                    void'(live_q.pop_front());
                    delivered++;
                end
            end
            if (nuke_valid)            m_pdg = 0;
            else if (br_mispred_valid) m_pdg = 1;
            if (ql) m_mp_robid = int'(br_mispred_robid);
            case (m_st)
                0:       m_st = 1;
                1:       if (nuke_valid) m_st = 2;
                default: if (resume_fetch && !nuke_valid) m_st = 1;
            endcase
        end

        @(posedge clk);
        #1;
        cyc++;
        nuke_valid = 1'b0; br_mispred_valid = 1'b0; resume_fetch = 1'b0;
    endtask

    task automatic mispredict(input int robid, input logic [31:0] target);
        br_mispred_valid  = 1'b1;
        br_mispred_robid  = ROBID_W'(robid);
        br_mispred_target = target;
        cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1; cycle(); reset = 1'b0;
    endtask

    initial begin
        int d0;
        reset = 1'b1; boot_pc = 32'h1000;
        nuke_valid = 0; nuke_pc = '0; resume_fetch = 0;
        br_mispred_valid = 0; br_mispred_robid = '0; br_mispred_target = '0;
        oldest_robid = '0; fb_req_ready = 0; fb_rsp_valid = 0; fb_rsp_id = '0;
        fb_rsp_instr = '0; decode_ready_de0 = 0;
        @(posedge clk); #1;
        cycle(); cycle();
        chk("rst_occ", 32'(fq_occupancy), 32'd0);
        chk("rst_req", 32'(fb_req_valid), 32'd0);
        reset = 1'b0;

        // In-order stream from boot PC, sustained one instruction per cycle.
        repeat (8) cycle();
        d0 = delivered;
        repeat (12) cycle();
        chk("sustain", 32'(delivered - d0), 32'd12);

        // Out-of-order returns 2,0,1: nothing reaches decode before slot 0 fills.
        do_reset();
        fb_manual = 1; fb_budget = 3;
        repeat (6) cycle();
        manual_id = 2; cycle(); cycle();
        chk("ooo_hold", 32'(valid_fe1), 32'd0);
        manual_id = 0; cycle();
        chk("ooo_head", 32'(valid_fe1), 32'd1);
        chk("ooo_pc", pc_fe1, 32'h1000);
        manual_id = 1; cycle(); cycle();
        fb_manual = 0; fb_budget = -1;
        repeat (10) cycle();

        // Mispredict with two fills outstanding.
        do_reset();
        fb_manual = 1; fb_budget = 2;
        repeat (5) cycle();
        chk("mp_occ", 32'(fq_occupancy), 32'd2);
        mispredict(10, 32'h2000);
        chk("mp_req_addr", fb_req_addr, 32'h2000);
        fb_manual = 0; fb_budget = -1;
        repeat (20) cycle();

        // Older-wins arbitration: robid 5, then 3 redirects, then 7 is ignored.
        do_reset();
        oldest_robid = '0;
        repeat (6) cycle();
        mispredict(5, 32'h5000); repeat (3) cycle();
        mispredict(3, 32'h3300); repeat (3) cycle();
        mispredict(7, 32'h7700); repeat (10) cycle();

        // Same-cycle nuke and mispredict: nuke wins, fetch parks until resume.
        nuke_valid = 1'b1; nuke_pc = 32'h3000;
        mispredict(1, 32'h4000);
        repeat (6) cycle();
        chk("nw_req", 32'(fb_req_valid), 32'd0);
        resume_fetch = 1'b1; cycle();
        chk("resume_addr", fb_req_addr, 32'h3000);
        repeat (10) cycle();

        // Decode stall with the queue full, then reset mid-stall to a new boot PC.
        dec_pct = 0;
        repeat (15) cycle();
        chk("stall_occ", 32'(fq_occupancy), 32'd4);
        chk("stall_req", 32'(fb_req_valid), 32'd0);
        repeat (10) cycle();
        boot_pc = 32'h8000;
        do_reset();
        chk("rst2_req", 32'(fb_req_valid), 32'd0);
        chk("rst2_vld", 32'(valid_fe1), 32'd0);
        chk("rst2_occ", 32'(fq_occupancy), 32'd0);
        chk("rst2_pc", fb_req_addr, 32'h8000);
        dec_pct = 100;
        repeat (10) cycle();

        // Randomized traffic: jittered out-of-order fills, stalls, redirects, nukes.
        rdy_pct = 70; dec_pct = 70; fb_lat = 1; fb_jitter = 4;
        for (int n = 0; n < 2000; n++) begin
            oldest_robid = ROBID_W'($urandom);
            if ($urandom_range(499) == 0) begin
                reset = 1'b1;
            end else begin
                reset = 1'b0;
                if ($urandom_range(99) < 3) begin
                    br_mispred_valid  = 1'b1;
                    br_mispred_robid  = ROBID_W'($urandom);
                    br_mispred_target = $urandom & 32'hFFFF_FFFC;
                end
                if ($urandom_range(99) < 2) begin
                    nuke_valid = 1'b1;
                    nuke_pc    = $urandom & 32'hFFFF_FFFC;
                end
                resume_fetch = $urandom_range(99) < 20;
            end
            cycle();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
